// File: rtl/riscv_pkg.sv
// Shared types for the boot-time instruction loader.
package riscv_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian byte image into instruction memory
// and holds the CPU fetch stage until the whole image has been written.
// Byte handshake: a byte moves on a rising edge where i_byte_valid and o_byte_ready are both high.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    loader_state_t     state, state_nxt;
    logic [7:0]        len_lo;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [23:0]       asm_q;

    logic              accept;
    logic [LEN_W-1:0]  hdr_n;
    logic              hdr_bad;
    logic              last_word;

    assign accept    = i_byte_valid && o_byte_ready;
    assign hdr_n     = {i_byte_data, len_lo};
    assign hdr_bad   = (hdr_n == '0) || (32'(hdr_n) > DEPTH);
    assign last_word = (32'(word_idx) == (32'(len) - 32'd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_start) state_nxt = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_nxt = hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (accept && lane == 2'd3 && last_word) state_nxt = ST_DONE;
            ST_DONE:   if (i_start) state_nxt = ST_LEN_LO;
            ST_ERR:    if (i_start) state_nxt = ST_LEN_LO;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_lo       <= '0;
            len          <= '0;
            word_idx     <= '0;
            lane         <= '0;
            asm_q        <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
        end else begin
            o_imem_we <= 1'b0;
            // Every new session starts from a clean lane and assembly register.
            if (state_nxt == ST_LEN_LO && state != ST_LEN_LO) begin
                lane  <= '0;
                asm_q <= '0;
            end
            case (state)
                ST_LEN_LO: if (accept) len_lo <= i_byte_data;
                ST_LEN_HI: begin
                    if (accept) begin
                        len      <= hdr_n;
                        word_idx <= '0;
                        lane     <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: asm_q[7:0]   <= i_byte_data;
                            2'd1: asm_q[15:8]  <= i_byte_data;
                            2'd2: asm_q[23:16] <= i_byte_data;
                            default: begin
                                o_imem_we    <= 1'b1;
                                o_imem_addr  <= word_idx;
                                o_imem_wdata <= {i_byte_data, asm_q};
                                // Index stops at the last word so it never wraps.
                                if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign o_done       = (state == ST_DONE);
    assign o_error      = (state == ST_ERR);
    // The final write lands in the first DONE cycle, so release the CPU one cycle later.
    assign o_cpu_hold   = !((state == ST_DONE) && !o_imem_we);

endmodule
